// File: rtl/branch_predictor_if.sv
// Predictor bus between the IF/EX pipeline logic and the branch predictor.
//   IF side : IF_PC in, Predict_Taken / Predict_PC out (combinational lookup)
//   EX side : EX_Branch, EX_PC, EX_Branch_Taken, EX_Target, EX_Predict_Taken in
//   Status  : Mispredict (combinational), Mispredict_Count (saturating)
// master = pipeline side, slave = predictor.
interface branch_predictor_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  IF_PC;
    logic                 Predict_Taken;
    logic [PC_WIDTH-1:0]  Predict_PC;
    logic                 EX_Branch;
    logic [PC_WIDTH-1:0]  EX_PC;
    logic                 EX_Branch_Taken;
    logic [PC_WIDTH-1:0]  EX_Target;
    logic                 EX_Predict_Taken;
    logic                 Mispredict;
    logic [CNT_WIDTH-1:0] Mispredict_Count;

    modport master (
        output IF_PC, EX_Branch, EX_PC, EX_Branch_Taken, EX_Target, EX_Predict_Taken,
        input  Predict_Taken, Predict_PC, Mispredict, Mispredict_Count
    );

    modport slave (
        input  IF_PC, EX_Branch, EX_PC, EX_Branch_Taken, EX_Target, EX_Predict_Taken,
        output Predict_Taken, Predict_PC, Mispredict, Mispredict_Count
    );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry, updated from resolved branches in EX.
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset (wins over a same-cycle update)
//   bp   : branch_predictor_if.slave -- fetch lookup, EX update, mispredict stats
module branch_predictor #(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_WIDTH-1:0] target;
        logic [1:0]          ctr;
    } entry_t;

    entry_t               tbl_q [ENTRIES];
    entry_t               upd_d;
    logic                 upd_we;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // PC[1:0] carries no information for the table.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.IF_PC[1:0], bp.EX_PC[1:0]};

    // ---------------- lookup (combinational, reads pre-update contents) ----
    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    entry_t              if_ent;
    logic                if_hit;

    assign if_idx = bp.IF_PC[IDX_BITS+1:2];
    assign if_tag = bp.IF_PC[PC_WIDTH-1:IDX_BITS+2];
    assign if_ent = tbl_q[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

    assign bp.Predict_Taken = if_hit && if_ent.ctr[1];
    assign bp.Predict_PC    = bp.Predict_Taken ? if_ent.target
                                               : bp.IF_PC + PC_WIDTH'(4);

    // ---------------- update from EX ---------------------------------------
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    entry_t              ex_ent;
    logic                ex_match;

    assign ex_idx   = bp.EX_PC[IDX_BITS+1:2];
    assign ex_tag   = bp.EX_PC[PC_WIDTH-1:IDX_BITS+2];
    assign ex_ent   = tbl_q[ex_idx];
    assign ex_match = ex_ent.valid && (ex_ent.tag == ex_tag);

    always_comb begin
        upd_d  = ex_ent;
        upd_we = 1'b0;
        if (bp.EX_Branch) begin
            if (bp.EX_Branch_Taken) begin
                upd_we = 1'b1;
                if (ex_match) begin
                    // A stale target is simply rewritten; not a mispredict.
                    upd_d.target = bp.EX_Target;
                    if (ex_ent.ctr != 2'b11) upd_d.ctr = ex_ent.ctr + 2'd1;
                end else begin
                    // Allocate over whatever was there, weakly taken.
                    upd_d.valid  = 1'b1;
                    upd_d.tag    = ex_tag;
                    upd_d.target = bp.EX_Target;
                    upd_d.ctr    = 2'b10;
                end
            end else if (ex_match) begin
                // Not-taken only trains existing entries; it never allocates.
                upd_we = 1'b1;
                if (ex_ent.ctr != 2'b00) upd_d.ctr = ex_ent.ctr - 2'd1;
            end
        end
    end

    // ---------------- mispredict statistics --------------------------------
    assign bp.Mispredict       = bp.EX_Branch && (bp.EX_Predict_Taken != bp.EX_Branch_Taken);
    assign bp.Mispredict_Count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (bp.Mispredict && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // ---------------- state ------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= '0;
                tbl_q[i].ctr    <= 2'b01;
            end
            cnt_q <= '0;
        end else begin
            if (upd_we) tbl_q[ex_idx] <= upd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues one cycle of stimulus
// and pushes the reference-model expectation; a monitor pops and compares on
// the following falling edge.
module tb_branch_predictor;
    localparam int PCW = 32;
    localparam int IDX = 4;
    localparam int CW  = 4;   // small counter so saturation is reachable
    localparam int NE  = 1 << IDX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bpi ();

    branch_predictor #(.PC_WIDTH(PCW), .IDX_BITS(IDX), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpi)
    );

    typedef struct {
        int          id;
        bit          chk;
        bit          pt;
        logic [31:0] ppc;
        bit          mp;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    // Reference model: table of plain ints/bits, counter as a clamped integer.
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];
    int          m_cnt;
    localparam int CNT_MAX = (1 << CW) - 1;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % NE);
    endfunction
    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction
    function automatic bit model_pred(logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic step(input bit r, input logic [31:0] ifpc, input bit exb,
                        input logic [31:0] expc, input bit ext,
                        input logic [31:0] extgt, input bit expt, input bit chk);
        exp_t e;
        int   i;
        bit   m;
        @(posedge clk);
        #1;
        rst                  = r;
        bpi.IF_PC            = ifpc;
        bpi.EX_Branch        = exb;
        bpi.EX_PC            = expc;
        bpi.EX_Branch_Taken  = ext;
        bpi.EX_Target        = extgt;
        bpi.EX_Predict_Taken = expt;
        step_id++;
        i     = idx_of(ifpc);
        e.id  = step_id;
        e.chk = chk;
        e.pt  = model_pred(ifpc);
        e.ppc = e.pt ? m_tgt[i] : ifpc + 32'd4;
        e.mp  = exb && (expt != ext);
        e.cnt = m_cnt;
        q.push_back(e);
        // advance the model to the state after the coming edge
        if (r) begin
            for (int k = 0; k < NE; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_cnt = 0;
        end else begin
            if (e.mp && m_cnt < CNT_MAX) m_cnt++;
            if (exb) begin
                i = idx_of(expc);
                m = m_valid[i] && (m_tag[i] == tag_of(expc));
                if (ext) begin
                    m_tgt[i] = extgt;
                    if (m) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else begin
                        m_valid[i] = 1'b1;
                        m_tag[i]   = tag_of(expc);
                        m_ctr[i]   = 2;
                    end
                end else if (m) begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask
    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pt);
        step(1'b0, pc, 1'b1, pc, t, tgt, pt, 1'b1);
    endtask

    // Monitor: outputs are always valid, so one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    n_chk++;
                    if (bpi.Predict_Taken !== e.pt) begin
                        n_fail++;
                        $display("FAIL predict_taken step=%0d got=%0b exp=%0b", e.id, bpi.Predict_Taken, e.pt);
                    end
                    n_chk++;
                    if (bpi.Predict_PC !== e.ppc) begin
                        n_fail++;
                        $display("FAIL predict_pc step=%0d got=%h exp=%h", e.id, bpi.Predict_PC, e.ppc);
                    end
                    n_chk++;
                    if (bpi.Mispredict !== e.mp) begin
                        n_fail++;
                        $display("FAIL mispredict step=%0d got=%0b exp=%0b", e.id, bpi.Mispredict, e.mp);
                    end
                    n_chk++;
                    if (bpi.Mispredict_Count !== CW'(e.cnt)) begin
                        n_fail++;
                        $display("FAIL mispredict_count step=%0d got=%0d exp=%0d", e.id, bpi.Mispredict_Count, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] pc, tgt;
        bit          t, pt;
        rst = 1'b1;
        bpi.IF_PC = '0; bpi.EX_Branch = 1'b0; bpi.EX_PC = '0;
        bpi.EX_Branch_Taken = 1'b0; bpi.EX_Target = '0; bpi.EX_Predict_Taken = 1'b0;

        // reset from unknown state, then reset values
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h40);

        // allocate and hit
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);

        // counter hysteresis
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look(32'h40);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        look(32'h40);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look(32'h40);
        repeat (3) upd(32'h40, 1'b0, 32'h0, 1'b1);
        look(32'h40);
        // still valid at 00: a taken update trains to 01, not a fresh 10
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);

        // aliasing at index 0
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        look(32'h80);
        upd(32'h80, 1'b1, 32'h200, 1'b0);
        look(32'h40);
        look(32'h80);

        // same-cycle collision: lookup sees old target
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 1'b1);
        look(32'h40);

        // +4 wrap and ignored low PC bits
        look(32'hFFFF_FFFC);
        look(32'h0000_0043);

        // randomized traffic over a small, aliasing-heavy PC set
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) pc = pc | 32'hFFFF_F000;
            tgt = $urandom & 32'hFFFF_FFFC;
            t   = 1'($urandom_range(0, 1));
            pt  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : model_pred(pc);
            step(($urandom_range(0, 49) == 0), 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2)),
                 1'($urandom_range(0, 2) != 0), pc, t, tgt, pt, 1'b1);
        end

        // counter saturation
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (17) upd(32'h500, 1'b0, 32'h0, 1'b1);
        look(32'h500);

        // reset beats a same-cycle update
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
        look(32'h40);

        // drain with a bounded wait
        begin
            int waited = 0;
            while (q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (q.size() > 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain pending=%0d required=0", q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
